// File: rtl/gpio_pkg.sv
// Register map shared by the GPIO input controller and the GPIO output register decode.
// Latency: n/a (constants only).
// Backpressure: n/a.
package gpio_pkg;

  // Width of the register strobe bus data path
  localparam int GPIO_DATA_W = 8;

  // Input-controller register addresses
  localparam logic [1:0] GPIO_IN_PIN  = 2'd0;  // debounced pin level, read-only
  localparam logic [1:0] GPIO_IN_STAT = 2'd1;  // sticky edge status, write-1-to-clear
  localparam logic [1:0] GPIO_IN_MASK = 2'd2;  // interrupt enable per pin
  localparam logic [1:0] GPIO_IN_SEL  = 2'd3;  // edge select per pin: 1 rising, 0 falling

endpackage : gpio_pkg

// File: rtl/gpio_debounce.sv
// One pin: synchroniser chain, debounce counter, stable level and edge pulses.
// Latency: pin change reaches level_o after SYNC_STAGES+DEB_CYCLES clock edges.
// Backpressure: none; free-running, edges are single-cycle pulses.
module gpio_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = $clog2(DEB_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   lvl_q, lvl_d;
  logic                   s;

  // Shift the raw pin into the metastability chain; oldest stage is the sampled value
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin_i};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Accept a new level only after DEB_CYCLES consecutive mismatching samples;
  // any agreeing sample restarts the count so short pulses are dropped
  always_comb begin
    cnt_d = cnt_q;
    lvl_d = lvl_q;
    if (s == lvl_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      lvl_d = s;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Synchroniser, counter and stable level registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      lvl_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
    end
  end

  // Edge pulses are taken from the pending level update so status can be
  // latched on the same clock edge that the level changes
  assign level_o = lvl_q;
  assign rise_o  = ~lvl_q &  lvl_d;
  assign fall_o  =  lvl_q & ~lvl_d;

endmodule : gpio_debounce

// File: rtl/gpio_in_ctrl.sv
// GPIO input controller: debounced pins, sticky W1C edge status, maskable level irq.
// Latency: pin to PIN register SYNC_STAGES+DEB_CYCLES edges; register writes take effect next edge.
// Backpressure: none; single-cycle write strobe always accepted, reads are combinational.
module gpio_in_ctrl
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gpio_in,
  input  logic [1:0]       addr,
  input  logic             we,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata,
  output logic             irq
);

  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_hit;

  logic [WIDTH-1:0] stat_q, stat_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] sel_q,  sel_d;
  logic [WIDTH-1:0] wbits;

  // One independent synchroniser/debouncer per pin
  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    gpio_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CYCLES  (DEB_CYCLES)
    ) u_deb (
      .clk     (clk),
      .rst_n   (rst_n),
      .pin_i   (gpio_in[i]),
      .level_o (level[i]),
      .rise_o  (rise[i]),
      .fall_o  (fall[i])
    );
  end

  assign wbits = wdata[WIDTH-1:0];

  // Pick the edge polarity each pin reports, using the registered select so a
  // select change never fabricates an edge of its own
  always_comb begin
    edge_hit = (rise & sel_q) | (fall & ~sel_q);
  end

  // Register file next state: W1C status where a new edge beats a clear,
  // plain read/write mask and select; PIN writes have no target
  always_comb begin
    stat_d = stat_q;
    mask_d = mask_q;
    sel_d  = sel_q;
    if (we && (addr == GPIO_IN_STAT)) begin
      stat_d = stat_q & ~wbits;
    end
    if (we && (addr == GPIO_IN_MASK)) begin
      mask_d = wbits;
    end
    if (we && (addr == GPIO_IN_SEL)) begin
      sel_d = wbits;
    end
    stat_d = stat_d | edge_hit;
  end

  // Register file state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q <= '0;
      mask_q <= '0;
      sel_q  <= '0;
    end else begin
      stat_q <= stat_d;
      mask_q <= mask_d;
      sel_q  <= sel_d;
    end
  end

  // Read mux, zero-extended above WIDTH
  always_comb begin
    rdata = '0;
    case (addr)
      GPIO_IN_PIN:  rdata[WIDTH-1:0] = level;
      GPIO_IN_STAT: rdata[WIDTH-1:0] = stat_q;
      GPIO_IN_MASK: rdata[WIDTH-1:0] = mask_q;
      GPIO_IN_SEL:  rdata[WIDTH-1:0] = sel_q;
      default:      rdata = '0;
    endcase
  end

  // Interrupt built from flops only, so raw pin activity cannot glitch it
  assign irq = |(stat_q & mask_q);

endmodule : gpio_in_ctrl

// File: tb/tb_gpio_in_ctrl.sv
// Directed bench for gpio_in_ctrl at default parameters.
// Latency: inputs driven 1ns after posedge, outputs sampled a few ns later.
// Backpressure: n/a.
module tb_gpio_in_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] gpio_in;
  logic [1:0] addr;
  logic       we;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       irq;

  int vectors;
  int miscompares;

  gpio_in_ctrl #(.WIDTH(8), .SYNC_STAGES(2), .DEB_CYCLES(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .gpio_in (gpio_in),
    .addr    (addr),
    .we      (we),
    .wdata   (wdata),
    .rdata   (rdata),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    addr  = a;
    we    = 1'b1;
    wdata = d;
    tick();
    we    = 1'b0;
    wdata = 8'h00;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    gpio_in = 8'h00;
    addr    = 2'd0;
    we      = 1'b0;
    wdata   = 8'h00;
    tick();
    for (int a = 0; a < 4; a++) begin
      addr = a[1:0];
      #1;
      vectors++;
      if (rdata !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_rdata addr=%0d got=%h exp=00", a, rdata);
      end
    end
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_irq got=%b exp=0", irq);
    end
    rst_n = 1'b1;
    addr  = 2'd0;
    for (int k = 0; k < 20; k++) begin
      tick();
      vectors++;
      if (rdata !== 8'h00 || irq !== 1'b0) begin
        miscompares++;
        $display("FAIL post_reset_idle cyc=%0d pin=%h irq=%b exp pin=00 irq=0", k, rdata, irq);
      end
    end
  endtask

  task automatic test_rise_latency();
    wr(2'd3, 8'h01);
    gpio_in = 8'h01;
    for (int k = 1; k <= 6; k++) begin
      tick();
      addr = 2'd0;
      #1;
      vectors++;
      if (rdata !== ((k == 6) ? 8'h01 : 8'h00)) begin
        miscompares++;
        $display("FAIL rise_pin edge=%0d got=%h exp=%h", k, rdata, (k == 6) ? 8'h01 : 8'h00);
      end
      addr = 2'd1;
      #1;
      vectors++;
      if (rdata !== ((k == 6) ? 8'h01 : 8'h00)) begin
        miscompares++;
        $display("FAIL rise_stat edge=%0d got=%h exp=%h", k, rdata, (k == 6) ? 8'h01 : 8'h00);
      end
    end
    wr(2'd1, 8'h01);
    addr = 2'd1;
    #1;
    vectors++;
    if (rdata !== 8'h00) begin
      miscompares++;
      $display("FAIL rise_w1c got=%h exp=00", rdata);
    end
  endtask

  task automatic test_pulse_filter();
    gpio_in = 8'h05;
    repeat (3) tick();
    gpio_in = 8'h01;
    repeat (8) tick();
    addr = 2'd0;
    #1;
    vectors++;
    if (rdata !== 8'h01) begin
      miscompares++;
      $display("FAIL pulse3_pin got=%h exp=01", rdata);
    end
    addr = 2'd1;
    #1;
    vectors++;
    if (rdata !== 8'h00) begin
      miscompares++;
      $display("FAIL pulse3_stat got=%h exp=00", rdata);
    end
    gpio_in = 8'h05;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 4) gpio_in = 8'h01;
    end
    addr = 2'd0;
    #1;
    vectors++;
    if (rdata !== 8'h05) begin
      miscompares++;
      $display("FAIL pulse4_pin got=%h exp=05", rdata);
    end
    repeat (6) tick();
    #1;
    vectors++;
    if (rdata !== 8'h01) begin
      miscompares++;
      $display("FAIL pulse4_release_pin got=%h exp=01", rdata);
    end
    addr = 2'd1;
    #1;
    vectors++;
    if (rdata !== 8'h04) begin
      miscompares++;
      $display("FAIL pulse4_fall_stat got=%h exp=04", rdata);
    end
    wr(2'd1, 8'h04);
    addr = 2'd1;
    #1;
    vectors++;
    if (rdata !== 8'h00) begin
      miscompares++;
      $display("FAIL pulse4_w1c got=%h exp=00", rdata);
    end
  endtask

  task automatic test_irq();
    wr(2'd2, 8'h04);
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_idle got=%b exp=0", irq);
    end
    gpio_in = 8'h05;
    repeat (8) tick();
    addr = 2'd1;
    #1;
    vectors++;
    if (rdata !== 8'h00 || irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_rise_ignored stat=%h irq=%b exp stat=00 irq=0", rdata, irq);
    end
    gpio_in = 8'h01;
    for (int k = 1; k <= 6; k++) begin
      tick();
      vectors++;
      if (irq !== (k == 6)) begin
        miscompares++;
        $display("FAIL irq_fall edge=%0d got=%b exp=%b", k, irq, (k == 6));
      end
    end
    wr(2'd2, 8'h00);
    addr = 2'd1;
    #1;
    vectors++;
    if (irq !== 1'b0 || rdata !== 8'h04) begin
      miscompares++;
      $display("FAIL irq_masked irq=%b stat=%h exp irq=0 stat=04", irq, rdata);
    end
    wr(2'd2, 8'h04);
    vectors++;
    if (irq !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_unmasked got=%b exp=1", irq);
    end
    addr  = 2'd1;
    we    = 1'b1;
    wdata = 8'h04;
    #1;
    vectors++;
    if (irq !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_before_w1c got=%b exp=1", irq);
    end
    tick();
    we    = 1'b0;
    wdata = 8'h00;
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_after_w1c got=%b exp=0", irq);
    end
  endtask

  task automatic test_w1c_collision();
    gpio_in = 8'h00;
    repeat (8) tick();
    addr = 2'd0;
    #1;
    vectors++;
    if (rdata !== 8'h00) begin
      miscompares++;
      $display("FAIL coll_pin_low got=%h exp=00", rdata);
    end
    gpio_in = 8'h01;
    repeat (5) tick();
    addr = 2'd1;
    #1;
    vectors++;
    if (rdata !== 8'h00) begin
      miscompares++;
      $display("FAIL coll_stat_pre got=%h exp=00", rdata);
    end
    we    = 1'b1;
    wdata = 8'h01;
    tick();
    we    = 1'b0;
    wdata = 8'h00;
    vectors++;
    if (rdata !== 8'h01) begin
      miscompares++;
      $display("FAIL coll_set_wins got=%h exp=01", rdata);
    end
    wr(2'd1, 8'h01);
    addr = 2'd1;
    #1;
    vectors++;
    if (rdata !== 8'h00) begin
      miscompares++;
      $display("FAIL coll_w1c_after got=%h exp=00", rdata);
    end
  endtask

  task automatic test_pin_readonly();
    wr(2'd0, 8'hFF);
    addr = 2'd0;
    #1;
    vectors++;
    if (rdata !== 8'h01) begin
      miscompares++;
      $display("FAIL ro_pin got=%h exp=01", rdata);
    end
    addr = 2'd2;
    #1;
    vectors++;
    if (rdata !== 8'h04) begin
      miscompares++;
      $display("FAIL ro_mask got=%h exp=04", rdata);
    end
    addr = 2'd3;
    #1;
    vectors++;
    if (rdata !== 8'h01) begin
      miscompares++;
      $display("FAIL ro_sel got=%h exp=01", rdata);
    end
  endtask

  task automatic test_reset_mid_debounce();
    gpio_in = 8'h03;
    repeat (4) tick();
    rst_n = 1'b0;
    for (int a = 0; a < 4; a++) begin
      addr = a[1:0];
      #1;
      vectors++;
      if (rdata !== 8'h00) begin
        miscompares++;
        $display("FAIL midrst_rdata addr=%0d got=%h exp=00", a, rdata);
      end
    end
    gpio_in = 8'h00;
    tick();
    tick();
    rst_n = 1'b1;
    addr  = 2'd0;
    repeat (10) tick();
    vectors++;
    if (rdata !== 8'h00) begin
      miscompares++;
      $display("FAIL midrst_pin_after got=%h exp=00", rdata);
    end
  endtask

  task automatic test_held_through_reset();
    rst_n   = 1'b0;
    gpio_in = 8'h01;
    tick();
    tick();
    rst_n = 1'b1;
    wr(2'd3, 8'h01);
    for (int k = 2; k <= 6; k++) begin
      tick();
      addr = 2'd0;
      #1;
      vectors++;
      if (rdata !== ((k == 6) ? 8'h01 : 8'h00)) begin
        miscompares++;
        $display("FAIL held_pin edge=%0d got=%h exp=%h", k, rdata, (k == 6) ? 8'h01 : 8'h00);
      end
    end
    addr = 2'd1;
    #1;
    vectors++;
    if (rdata !== 8'h01) begin
      miscompares++;
      $display("FAIL held_rise_stat got=%h exp=01", rdata);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_rise_latency();
    test_pulse_filter();
    test_irq();
    test_w1c_collision();
    test_pin_readonly();
    test_reset_mid_debounce();
    test_held_through_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_gpio_in_ctrl
